// File: rtl/dm_responder_if.sv
// Data-memory bus between the core's MEM stage (master) and dm_responder (slave).
//   DM_enable  : bus enable; nothing takes effect while low
//   DM_read    : read request, answered combinationally on DM_out
//   DM_write   : write request, committed at the next rising clock edge
//   DM_address : byte address (bits [1:0] ignored by the responder)
//   DM_in      : write data
//   DM_out     : read data, zero unless DM_enable && DM_read
//   timer_irq  : level interrupt from the timer block
interface dm_responder_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  DM_enable;
  logic                  DM_read;
  logic                  DM_write;
  logic [ADDR_WIDTH-1:0] DM_address;
  logic [DATA_WIDTH-1:0] DM_in;
  logic [DATA_WIDTH-1:0] DM_out;
  logic                  timer_irq;

  modport master (
    output DM_enable, DM_read, DM_write, DM_address, DM_in,
    input  DM_out, timer_irq
  );

  modport slave (
    input  DM_enable, DM_read, DM_write, DM_address, DM_in,
    output DM_out, timer_irq
  );
endinterface

// File: rtl/dm_responder.sv
// Memory-side end of the core's DM_* bus: word RAM in the lower half of the address
// space and a timer/counter register block in the upper half.
//   clk : system clock
//   rst : asynchronous active-low reset (RAM contents are not reset)
//   dm  : dm_responder_if slave port (see interface for signal list)
// Register map (upper half, word offsets): 0 CYCLE (ro), 1 TIMER_CNT, 2 TIMER_CMP,
// 3 CTRL {irq_en, auto_reload, en}, 4 STATUS {expired} w1c, 5 SCRATCH; others read 0.
module dm_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_WORDS  = 512
) (
  input logic           clk,
  input logic           rst,
  dm_responder_if.slave dm
);
  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam int unsigned RegAw = ADDR_WIDTH - 3;

  localparam logic [RegAw-1:0] RegCycle   = RegAw'(0);
  localparam logic [RegAw-1:0] RegCnt     = RegAw'(1);
  localparam logic [RegAw-1:0] RegCmp     = RegAw'(2);
  localparam logic [RegAw-1:0] RegCtrl    = RegAw'(3);
  localparam logic [RegAw-1:0] RegStatus  = RegAw'(4);
  localparam logic [RegAw-1:0] RegScratch = RegAw'(5);

  logic [DATA_WIDTH-1:0] r_ram [RAM_WORDS];
  logic [DATA_WIDTH-1:0] r_cycle;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_cmp;
  logic [DATA_WIDTH-1:0] r_scratch;
  logic [2:0]            r_ctrl;
  logic                  r_expired;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_reg_sel;
  logic [RamAw-1:0]      w_ram_idx;
  logic [RegAw-1:0]      w_reg_idx;
  logic                  w_wr_cnt;
  logic                  w_wr_cmp;
  logic                  w_wr_ctrl;
  logic                  w_wr_status;
  logic                  w_wr_scratch;
  logic                  w_match;
  logic                  w_set;
  logic [DATA_WIDTH-1:0] w_cnt_nxt;
  logic [2:0]            w_ctrl_nxt;
  logic                  w_expired_nxt;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused_addr;

  assign w_rd      = dm.DM_enable & dm.DM_read;
  assign w_wr      = dm.DM_enable & dm.DM_write;
  assign w_reg_sel = dm.DM_address[ADDR_WIDTH-1];
  assign w_ram_idx = dm.DM_address[RamAw+1:2];
  assign w_reg_idx = dm.DM_address[ADDR_WIDTH-2:2];
  // No byte lanes: the low address bits are deliberately dropped.
  assign w_unused_addr = ^dm.DM_address[1:0];

  assign w_wr_cnt     = w_wr & w_reg_sel & (w_reg_idx == RegCnt);
  assign w_wr_cmp     = w_wr & w_reg_sel & (w_reg_idx == RegCmp);
  assign w_wr_ctrl    = w_wr & w_reg_sel & (w_reg_idx == RegCtrl);
  assign w_wr_status  = w_wr & w_reg_sel & (w_reg_idx == RegStatus);
  assign w_wr_scratch = w_wr & w_reg_sel & (w_reg_idx == RegScratch);

  // Match uses pre-edge values; a bus load of TIMER_CNT suppresses the match action.
  assign w_match = r_ctrl[0] & (r_cnt == r_cmp);
  assign w_set   = w_match & ~w_wr_cnt;

  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_ctrl_nxt    = r_ctrl;
    w_expired_nxt = r_expired;
    if (w_wr_cnt) begin
      w_cnt_nxt = dm.DM_in;
    end else if (w_match) begin
      if (r_ctrl[1]) w_cnt_nxt = '0;
      else           w_ctrl_nxt[0] = 1'b0;  // one-shot disarm
    end else if (r_ctrl[0]) begin
      w_cnt_nxt = r_cnt + DATA_WIDTH'(1);
    end
    // A CTRL write overrides the one-shot disarm.
    if (w_wr_ctrl) w_ctrl_nxt = dm.DM_in[2:0];
    // Set beats a simultaneous write-1-to-clear.
    if (w_set) w_expired_nxt = 1'b1;
    else if (w_wr_status && dm.DM_in[0]) w_expired_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle   <= '0;
      r_cnt     <= '0;
      r_cmp     <= '0;
      r_scratch <= '0;
      r_ctrl    <= '0;
      r_expired <= 1'b0;
    end else begin
      r_cycle   <= r_cycle + DATA_WIDTH'(1);
      r_cnt     <= w_cnt_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_expired <= w_expired_nxt;
      if (w_wr_cmp)     r_cmp     <= dm.DM_in;
      if (w_wr_scratch) r_scratch <= dm.DM_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !w_reg_sel) r_ram[w_ram_idx] <= dm.DM_in;
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      if (!w_reg_sel) begin
        w_rdata = r_ram[w_ram_idx];
      end else begin
        case (w_reg_idx)
          RegCycle:   w_rdata = r_cycle;
          RegCnt:     w_rdata = r_cnt;
          RegCmp:     w_rdata = r_cmp;
          RegCtrl:    w_rdata = {{(DATA_WIDTH-3){1'b0}}, r_ctrl};
          RegStatus:  w_rdata = {{(DATA_WIDTH-1){1'b0}}, r_expired};
          RegScratch: w_rdata = r_scratch;
          default:    w_rdata = '0;
        endcase
      end
    end
  end

  assign dm.DM_out    = w_rdata;
  assign dm.timer_irq = r_expired & r_ctrl[2];
endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dm_bus ();

  dm_responder #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(32),
    .RAM_WORDS (512)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dm (dm_bus)
  );

  // Reference state, updated from the register-map rules once per clock.
  logic [31:0] m_ram [512];
  logic [31:0] m_cycle, m_cnt, m_cmp, m_scratch;
  logic [2:0]  m_ctrl;
  logic        m_exp;

  int checks   = 0;
  int failures = 0;
  logic [31:0] obs;
  logic        obs_irq;

  function automatic logic [31:0] model_read(logic en, logic rd, logic [11:0] a);
    if (!(en && rd)) return 32'h0;
    if (!a[11]) return m_ram[a[10:2]];
    case (a[10:2])
      9'd0:    return m_cycle;
      9'd1:    return m_cnt;
      9'd2:    return m_cmp;
      9'd3:    return {29'b0, m_ctrl};
      9'd4:    return {31'b0, m_exp};
      9'd5:    return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_cycle = 0; m_cnt = 0; m_cmp = 0; m_scratch = 0; m_ctrl = 0; m_exp = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive, check combinational outputs mid-cycle, clock, advance the model.
  task automatic cyc(input string tag, input logic en, input logic rd, input logic wr,
                     input logic [11:0] a, input logic [31:0] d);
    logic        we, match, hit, is_reg;
    logic [8:0]  idx;
    logic [31:0] n_cnt;
    logic [2:0]  n_ctrl;
    logic        n_exp;
    dm_bus.DM_enable  = en;
    dm_bus.DM_read    = rd;
    dm_bus.DM_write   = wr;
    dm_bus.DM_address = a;
    dm_bus.DM_in      = d;
    #2;
    obs     = dm_bus.DM_out;
    obs_irq = dm_bus.timer_irq;
    chk({tag, "/out"}, obs, model_read(en, rd, a));
    chk({tag, "/irq"}, {31'b0, obs_irq}, {31'b0, m_exp & m_ctrl[2]});
    @(posedge clk);
    #1;
    we     = en && wr;
    is_reg = a[11];
    idx    = a[10:2];
    match  = m_ctrl[0] && (m_cnt == m_cmp);
    hit    = 1'b0;
    n_cnt  = m_cnt;
    n_ctrl = m_ctrl;
    n_exp  = m_exp;
    if (we && !is_reg) m_ram[idx] = d;
    if (we && is_reg && idx == 9'd1) begin
      n_cnt = d;
    end else if (match) begin
      hit   = 1'b1;
      n_exp = 1'b1;
      if (m_ctrl[1]) n_cnt = 0;
      else n_ctrl[0] = 1'b0;
    end else if (m_ctrl[0]) begin
      n_cnt = m_cnt + 1;
    end
    if (we && is_reg && idx == 9'd3) n_ctrl = d[2:0];
    if (we && is_reg && idx == 9'd4 && d[0] && !hit) n_exp = 1'b0;
    if (we && is_reg && idx == 9'd2) m_cmp = d;
    if (we && is_reg && idx == 9'd5) m_scratch = d;
    m_cnt   = n_cnt;
    m_ctrl  = n_ctrl;
    m_exp   = n_exp;
    m_cycle = m_cycle + 1;
  endtask

  initial begin
    logic [31:0] c1;
    logic [11:0] a;
    logic [11:0] regs [8];
    regs[0] = 12'h800; regs[1] = 12'h804; regs[2] = 12'h808; regs[3] = 12'h80C;
    regs[4] = 12'h810; regs[5] = 12'h814; regs[6] = 12'h818; regs[7] = 12'hFFC;

    rst = 1'b0;
    dm_bus.DM_enable = 0; dm_bus.DM_read = 0; dm_bus.DM_write = 0;
    dm_bus.DM_address = 0; dm_bus.DM_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", dm_bus.DM_out, 32'h0);
    chk("reset_irq", {31'b0, dm_bus.timer_irq}, 32'h0);
    dm_bus.DM_enable = 1; dm_bus.DM_read = 1; dm_bus.DM_address = 12'h804;
    #1 chk("reset_cnt", dm_bus.DM_out, 32'h0);
    dm_bus.DM_address = 12'h80C;
    #1 chk("reset_ctrl", dm_bus.DM_out, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    cyc("cycle0", 1, 1, 0, 12'h800, 0);
    chk("cycle_start", obs, 32'h0);

    // RAM words used by the random phase are preloaded so they are never read undefined.
    for (int i = 16; i < 32; i++) cyc("fill", 1, 0, 1, 12'(i * 4), $urandom);

    // RAM basics and same-cycle read/write
    cyc("w014", 1, 0, 1, 12'h014, 32'hDEADBEEF);
    cyc("r014", 1, 1, 0, 12'h014, 0);
    chk("ram_rd", obs, 32'hDEADBEEF);
    cyc("r016", 1, 1, 0, 12'h016, 0);
    chk("ram_rd_lowbits", obs, 32'hDEADBEEF);
    cyc("r014_nord", 1, 0, 0, 12'h014, 0);
    chk("ram_no_read", obs, 32'h0);
    cyc("w020", 1, 0, 1, 12'h020, 32'h1);
    cyc("rw020", 1, 1, 1, 12'h020, 32'h2);
    chk("rw_old", obs, 32'h1);
    cyc("r020", 1, 1, 0, 12'h020, 0);
    chk("rw_new", obs, 32'h2);

    // One-shot timer
    cyc("os_cnt", 1, 0, 1, 12'h804, 0);
    cyc("os_cmp", 1, 0, 1, 12'h808, 5);
    cyc("os_ctrl", 1, 0, 1, 12'h80C, 5);
    for (int i = 0; i < 6; i++) begin
      cyc("os_run", 1, 1, 0, 12'h804, 0);
      chk("os_count", obs, 32'(i));
    end
    cyc("os_rctrl", 1, 1, 0, 12'h80C, 0);
    chk("os_en_cleared", obs, 32'h4);
    chk("os_irq_set", {31'b0, obs_irq}, 32'h1);
    cyc("os_rcnt", 1, 1, 0, 12'h804, 0);
    chk("os_cnt_hold", obs, 32'h5);
    cyc("os_rstat", 1, 1, 0, 12'h810, 0);
    chk("os_expired", obs, 32'h1);
    cyc("os_w0", 1, 0, 1, 12'h810, 0);
    cyc("os_rstat0", 1, 1, 0, 12'h810, 0);
    chk("os_w0_noeffect", obs, 32'h1);
    cyc("os_clr", 1, 0, 1, 12'h810, 1);
    cyc("os_rstat2", 1, 1, 0, 12'h810, 0);
    chk("os_cleared", obs, 32'h0);
    chk("os_irq_clear", {31'b0, obs_irq}, 32'h0);

    // Auto-reload and clear/set collision
    cyc("ar_cnt", 1, 0, 1, 12'h804, 0);
    cyc("ar_cmp", 1, 0, 1, 12'h808, 2);
    cyc("ar_ctrl", 1, 0, 1, 12'h80C, 7);
    for (int i = 0; i < 9; i++) begin
      cyc("ar_run", 1, 1, 0, 12'h804, 0);
      chk("ar_seq", obs, 32'(i % 3));
    end
    for (int i = 0; i < 4 && m_cnt != 2; i++) cyc("ar_wait", 1, 0, 0, 12'h804, 0);
    cyc("ar_clr_match", 1, 0, 1, 12'h810, 1);
    cyc("ar_rstat", 1, 1, 0, 12'h810, 0);
    chk("ar_set_wins", obs, 32'h1);
    cyc("ar_clr", 1, 0, 1, 12'h810, 1);
    cyc("ar_rstat2", 1, 1, 0, 12'h810, 0);
    chk("ar_cleared", obs, 32'h0);
    cyc("ar_stop", 1, 0, 1, 12'h80C, 0);

    // Register region
    cyc("cy_r1", 1, 1, 0, 12'h800, 0);
    c1 = obs;
    cyc("cy_w", 1, 0, 1, 12'h800, 32'h0);
    cyc("cy_r2", 1, 1, 0, 12'h800, 0);
    chk("cycle_ro", obs, c1 + 2);
    cyc("sc_w", 1, 0, 1, 12'h814, 32'hA5A5A5A5);
    cyc("sc_r", 1, 1, 0, 12'h814, 0);
    chk("scratch", obs, 32'hA5A5A5A5);
    cyc("ffc_r", 1, 1, 0, 12'hFFC, 0);
    chk("unmapped", obs, 32'h0);
    cyc("sc_wdis", 0, 0, 1, 12'h814, 32'h12345678);
    cyc("sc_r2", 1, 1, 0, 12'h814, 0);
    chk("scratch_disabled_wr", obs, 32'hA5A5A5A5);

    // Random traffic over the register block and the preloaded RAM words
    for (int n = 0; n < 400; n++) begin
      logic [31:0] d;
      if ($urandom_range(0, 2) == 0) a = 12'(($urandom_range(16, 31) * 4));
      else a = regs[$urandom_range(0, 7)];
      a = a | 12'($urandom_range(0, 3));
      case (a & 12'hFFC)
        12'h804, 12'h808: d = $urandom_range(0, 6);
        12'h80C:          d = $urandom_range(0, 7);
        default:          d = $urandom;
      endcase
      cyc("rand", $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, a, d);
    end

    // Async reset while the timer runs with irq asserted
    cyc("rs_cnt", 1, 0, 1, 12'h804, 0);
    cyc("rs_cmp", 1, 0, 1, 12'h808, 1);
    cyc("rs_ctrl", 1, 0, 1, 12'h80C, 7);
    cyc("rs_run1", 1, 1, 0, 12'h804, 0);
    cyc("rs_run2", 1, 1, 0, 12'h804, 0);
    cyc("rs_run3", 1, 1, 0, 12'h804, 0);
    chk("rs_irq_before", {31'b0, obs_irq}, 32'h1);
    #2;
    rst = 1'b0;
    dm_bus.DM_enable = 1; dm_bus.DM_read = 1; dm_bus.DM_write = 0;
    dm_bus.DM_address = 12'h810;
    #1;
    chk("rs_irq_now", {31'b0, dm_bus.timer_irq}, 32'h0);
    chk("rs_status", dm_bus.DM_out, 32'h0);
    dm_bus.DM_address = 12'h80C;
    #1 chk("rs_ctrl0", dm_bus.DM_out, 32'h0);
    dm_bus.DM_address = 12'h800;
    #1 chk("rs_cycle0", dm_bus.DM_out, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc("rs_r014", 1, 1, 0, 12'h014, 0);
    chk("rs_ram_kept", obs, 32'hDEADBEEF);
    cyc("rs_r020", 1, 1, 0, 12'h020, 0);
    chk("rs_ram_kept2", obs, 32'h2);
    cyc("rs_rcyc", 1, 1, 0, 12'h800, 0);
    chk("rs_cycle_restart", obs, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder: the memory-side end of the core's DM_* interface.
- Serves word reads and writes to an on-chip RAM region and to a memory-mapped timer/counter register region.
- Read data is combinational, because the core's MEM stage samples DM_out in the same cycle the address is presented.
- Writes and all counters are clocked.

Parameters:
- ADDR_WIDTH, 12, byte-address width of DM_address.
- DATA_WIDTH, 32, word width.
- RAM_WORDS, 512, RAM depth in words; occupies byte range 0x000-0x7FF.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- DM_enable  input  1  bus enable; when low, no read or write takes effect.
- DM_read  input  1  read request, valid in the current cycle.
- DM_write  input  1  write request, committed at the next rising clk edge.
- DM_address  input  ADDR_WIDTH  byte address.
- DM_in  input  DATA_WIDTH  write data.
- DM_out  output  DATA_WIDTH  read data, combinational.
- timer_irq  output  1  level interrupt; equals STATUS.expired AND CTRL.irq_en.

Behaviour:
- Reset (rst low, asynchronous):
  - CYCLE, TIMER_CNT, TIMER_CMP, CTRL, expired and SCRATCH all clear to 0.
  - timer_irq = 0.
  - RAM contents are not reset.
  - DM_out = 0, because DM_read is low during reset.
- Addressing:
  - Word index = DM_address[ADDR_WIDTH-1:2].
  - DM_address[1:0] is ignored; there is no byte-lane support.
  - DM_address[11] = 0 selects RAM, word DM_address[10:2].
  - DM_address[11] = 1 selects the register region.
- Register map:
  - 0x800 CYCLE: read-only.
  - 0x804 TIMER_CNT: read/write.
  - 0x808 TIMER_CMP: read/write.
  - 0x80C CTRL: read/write. bit0 = en, bit1 = auto_reload, bit2 = irq_en.
  - 0x810 STATUS: bit0 = expired; write-1-to-clear.
  - 0x814 SCRATCH: read/write.
  - Any other register-region address reads 0 and ignores writes.
- Reads:
  - DM_out = selected data when DM_enable && DM_read; otherwise 0.
  - Latency 0: purely combinational from address and state.
- Writes:
  - Occur at the posedge when DM_enable && DM_write.
  - A write to CYCLE is ignored.
- Read and write to the same address in the same cycle: DM_out returns the old value; the new value is visible from the next cycle.
- CYCLE: increments every clk after reset; wraps 0xFFFFFFFF -> 0.
- Timer, evaluated each posedge:
  - Priority 1: a bus write to TIMER_CNT loads DM_in. This overrides increment and reload.
  - Priority 2: else if en && TIMER_CNT == TIMER_CMP:
    - expired is set to 1.
    - If auto_reload: TIMER_CNT <= 0.
    - Otherwise: TIMER_CNT holds and en clears to 0 (one-shot).
  - Priority 3: else if en: TIMER_CNT <= TIMER_CNT + 1, wrapping 0xFFFFFFFF -> 0.
  - Priority 4: else TIMER_CNT holds.
- Match is evaluated on pre-edge register values. A same-cycle write to TIMER_CMP affects matching only from the next cycle.
- One-shot en clear vs CTRL write: a CTRL write in the match cycle wins over the one-shot en clear.
- STATUS clear vs new match in the same cycle: set wins; expired stays 1.
- Writing 0 to STATUS bit0 has no effect.
- timer_irq is the registered expired flag ANDed with irq_en. It is glitch-free with respect to the bus.
- DM_enable low: no state changes except CYCLE and timer progression.

Test Plan:
- RAM write/read: write 0xDEADBEEF to 0x014, read 0x014 next cycle -> DM_out = 0xDEADBEEF. Read 0x016 -> same word. Read with DM_read = 0 -> 0.
- Same-cycle read+write: RAM[0x020] = 0x1; in one cycle read and write 0x2 to 0x020 -> DM_out = 0x1 that cycle and 0x2 the next cycle.
- One-shot timer:
  - Write CMP = 5, CTRL = 0x5 (en, irq_en).
  - TIMER_CNT counts 0..5.
  - On the edge after CNT = 5: expired = 1, timer_irq = 1, CTRL.en reads 0, CNT holds 5.
  - Write 0x1 to STATUS -> timer_irq = 0 next cycle.
- Auto-reload with clear collision:
  - CMP = 2, CTRL = 0x7.
  - CNT sequence is 0,1,2,0,1,2,...; expired re-sets every 3 cycles.
  - A STATUS clear issued in a match cycle leaves expired = 1.
- Register region:
  - Writes to CYCLE are ignored; CYCLE keeps incrementing.
  - SCRATCH write of 0xA5A5A5A5 reads back 0xA5A5A5A5.
  - Read of 0xFFC -> 0.
  - DM_enable = 0 write to SCRATCH -> no change.
- Async reset mid-count: pull rst low between clk edges while the timer runs -> all registers and timer_irq go to 0 immediately; RAM contents written before reset are still readable after rst is released.
